// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/response bundle used by the fetch
//               unit. The request (imem_req/imem_addr) is held stable until a
//               clock edge samples imem_ready=1.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : fetch address (fetch -> memory)
//   imem_ready : memory returns data this cycle (memory -> fetch)
//   imem_rdata : instruction word, valid with imem_ready (memory -> fetch)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : IF-stage fetch unit. Owns the program counter, issues requests
//               to instruction memory and hands PC_F / Instr_F / PC_Plus4_F to
//               the IF->ID register. Absorbs memory latency, hazard stalls and
//               decode-stage redirects.
//   clk, reset  : clock, synchronous active-high reset
//   StallF      : hazard-unit stall
//   PCSrcD      : decode-stage redirect request
//   PCBranchD   : redirect target (bits [1:0] dropped)
//   imem        : instruction-memory request/response bundle (master side)
//   PC_F        : current PC
//   PC_Plus4_F  : PC_F + 4 (wraps)
//   Instr_F     : fetched instruction, 0 when FetchValid=0
//   FetchValid  : Instr_F is a real instruction for PC_F
//   ImemStallF  : fetch is not delivering this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         PCSrcD,
  input  logic [31:0]  PCBranchD,
  fetch_unit_if.master imem,
  output logic [31:0]  PC_F,
  output logic [31:0]  PC_Plus4_F,
  output logic [31:0]  Instr_F,
  output logic         FetchValid,
  output logic         ImemStallF
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request outstanding for r_pc
    S_HOLD  = 2'd1,  // word captured in r_buf, waiting for StallF to drop
    S_DRAIN = 2'd2   // old request still in flight, redirect pending in r_tgt
  } state_t;

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc,    w_pc_nxt;
  logic [31:0] r_buf,   w_buf_nxt;
  logic [31:0] r_tgt,   w_tgt_nxt;

  logic        w_redir;
  logic [31:0] w_br_aligned;
  logic [31:0] w_pc_inc;
  logic        w_req;
  logic        w_valid;
  logic [31:0] w_instr;
  logic        w_istall;

  // A stall blocks the redirect; the branch will be re-presented later.
  assign w_redir      = PCSrcD & ~StallF;
  assign w_br_aligned = PCBranchD & c_ALIGN_MASK;
  assign w_pc_inc     = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC & c_ALIGN_MASK;
      r_buf   <= 32'h0;
      r_tgt   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_tgt_nxt   = r_tgt;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    w_instr     = 32'h0;
    w_istall    = 1'b0;

    unique case (r_state)
      S_REQ: begin
        w_req = 1'b1;
        if (imem.imem_ready) begin
          w_valid = 1'b1;
          w_instr = imem.imem_rdata;
          if (StallF) begin
            w_buf_nxt   = imem.imem_rdata;
            w_state_nxt = S_HOLD;
          end else if (PCSrcD) begin
            w_pc_nxt = w_br_aligned;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end else begin
          w_istall = 1'b1;
          // The address must not change while the request is pending, so the
          // redirect is parked until the in-flight word comes back.
          if (w_redir) begin
            w_tgt_nxt   = w_br_aligned;
            w_state_nxt = S_DRAIN;
          end
        end
      end

      S_HOLD: begin
        w_valid = 1'b1;
        w_instr = r_buf;
        if (!StallF) begin
          w_pc_nxt    = PCSrcD ? w_br_aligned : w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end

      S_DRAIN: begin
        w_req    = 1'b1;
        w_istall = 1'b1;
        if (w_redir) begin
          w_tgt_nxt = w_br_aligned;
        end
        if (imem.imem_ready) begin
          // Returned word belongs to the abandoned path and is discarded.
          w_pc_nxt    = w_redir ? w_br_aligned : r_tgt;
          w_state_nxt = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    // Nothing is requested or delivered while reset is held.
    if (reset) begin
      w_req    = 1'b0;
      w_valid  = 1'b0;
      w_instr  = 32'h0;
      w_istall = 1'b0;
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign PC_F           = r_pc;
  assign PC_Plus4_F     = w_pc_inc;
  assign Instr_F        = w_instr;
  assign FetchValid     = w_valid;
  assign ImemStallF     = w_istall;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A directed vector table
//               walks the documented scenarios, then random traffic is checked
//               against a behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        st;
  logic        ps;
  logic [31:0] br;
  logic        rdy;
  logic [31:0] pc_f, pc4_f, instr_f;
  logic        fv, istall;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit_if bus ();

  // Memory returns an address-tagged word so every fetched word is traceable.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_ready = rdy;
  assign bus.imem_rdata = tag(bus.imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (rst),
    .StallF     (st),
    .PCSrcD     (ps),
    .PCBranchD  (br),
    .imem       (bus.master),
    .PC_F       (pc_f),
    .PC_Plus4_F (pc4_f),
    .Instr_F    (instr_f),
    .FetchValid (fv),
    .ImemStallF (istall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int row);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic chk_pc, input logic [31:0] epc,
                           input logic ereq, input logic efv, input logic [31:0] einstr,
                           input logic eistall);
    if (chk_pc) begin
      chk("PC_F",       pc_f,          epc,          row);
      chk("PC_Plus4_F", pc4_f,         epc + 32'd4,  row);
      chk("imem_addr",  bus.imem_addr, epc,          row);
    end
    chk("imem_req",   {31'h0, bus.imem_req}, {31'h0, ereq},    row);
    chk("FetchValid", {31'h0, fv},           {31'h0, efv},     row);
    chk("Instr_F",    instr_f,               einstr,           row);
    chk("ImemStallF", {31'h0, istall},       {31'h0, eistall}, row);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst, st, ps;
    logic [31:0] br;
    logic        rdy;
    logic        chk_pc;
    logic [31:0] pc;
    logic        req, fv, istall;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic s, input logic p, input logic [31:0] b,
                     input logic rd, input logic cp, input logic [31:0] epc,
                     input logic erq, input logic efv, input logic eis);
    vec_t v;
    v.rst = r; v.st = s; v.ps = p; v.br = b; v.rdy = rd;
    v.chk_pc = cp; v.pc = epc; v.req = erq; v.fv = efv; v.istall = eis;
    vt.push_back(v);
  endtask

  // --------------------------------------------------------- reference model
  // The model tracks "what the fetch stage is doing" rather than an encoding:
  // whether a word is being held for the stalled decode, and whether a redirect
  // is waiting for an abandoned memory access to finish.
  logic [31:0] m_pc;
  logic        m_known;
  logic        m_holding;
  logic [31:0] m_held_word;
  logic        m_redirect_waiting;
  logic [31:0] m_redirect_to;

  initial begin
    rst = 1'b1; st = 1'b0; ps = 1'b0; br = 32'h0; rdy = 1'b0;

    //   rst st ps br            rdy chk pc            req fv isr
    add(1, 0, 0, 32'h0,          1,  0, 32'h0,         0,  0,  0);
    add(1, 0, 0, 32'h0,          1,  1, 32'h0,         0,  0,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h0,         1,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h4,         1,  1,  0);
    add(0, 0, 0, 32'h0,          0,  1, 32'h8,         1,  0,  1);  // slow memory at 8
    add(0, 0, 0, 32'h0,          0,  1, 32'h8,         1,  0,  1);
    add(0, 0, 0, 32'h0,          1,  1, 32'h8,         1,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'hC,         1,  1,  0);
    add(0, 1, 0, 32'h0,          1,  1, 32'h10,        1,  1,  0);  // stall on ready at 16
    add(0, 1, 0, 32'h0,          0,  1, 32'h10,        0,  1,  0);
    add(0, 1, 0, 32'h0,          0,  1, 32'h10,        0,  1,  0);
    add(0, 0, 0, 32'h0,          0,  1, 32'h10,        0,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h14,        1,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h18,        1,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h1C,        1,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'h20,        1,  1,  0);
    add(0, 0, 1, 32'h100,        0,  1, 32'h24,        1,  0,  1);  // redirect while pending
    add(0, 0, 0, 32'h0,          0,  1, 32'h24,        1,  0,  1);
    add(0, 0, 0, 32'h0,          1,  1, 32'h24,        1,  0,  1);
    add(0, 0, 0, 32'h0,          1,  1, 32'h100,       1,  1,  0);
    add(0, 0, 1, 32'h43,         1,  1, 32'h104,       1,  1,  0);  // zero-wait redirect
    add(0, 1, 1, 32'h300,        0,  1, 32'h40,        1,  0,  1);  // stall blocks redirect
    add(0, 1, 1, 32'h300,        1,  1, 32'h40,        1,  1,  0);
    add(0, 1, 1, 32'h300,        0,  1, 32'h40,        0,  1,  0);
    add(0, 0, 0, 32'h0,          0,  1, 32'h40,        0,  1,  0);
    add(0, 0, 1, 32'h500,        0,  1, 32'h44,        1,  0,  1);  // enter DRAIN
    add(1, 0, 0, 32'h0,          0,  1, 32'h44,        0,  0,  0);  // reset mid-DRAIN
    add(0, 0, 0, 32'h0,          1,  1, 32'h0,         1,  1,  0);
    add(0, 0, 1, 32'h203,        1,  1, 32'h4,         1,  1,  0);
    add(0, 0, 1, 32'hFFFF_FFFF,  1,  1, 32'h200,       1,  1,  0);
    add(0, 0, 0, 32'h0,          1,  1, 32'hFFFF_FFFC, 1,  1,  0);  // wrap
    add(0, 0, 0, 32'h0,          1,  1, 32'h0,         1,  1,  0);

    foreach (vt[i]) begin
      rst = vt[i].rst; st = vt[i].st; ps = vt[i].ps; br = vt[i].br; rdy = vt[i].rdy;
      #1;
      check_all(i, vt[i].chk_pc, vt[i].pc, vt[i].req, vt[i].fv,
                vt[i].fv ? tag(vt[i].pc) : 32'h0, vt[i].istall);
      @(posedge clk);
      #1;
    end

    // ------------------------------------------------------ random traffic
    m_known            = 1'b0;
    m_pc               = 32'h0;
    m_holding          = 1'b0;
    m_held_word        = 32'h0;
    m_redirect_waiting = 1'b0;
    m_redirect_to      = 32'h0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_req, e_fv, e_is;
      logic [31:0] e_instr, word, br_al;
      logic        take;

      rst = (cyc < 2) || ($urandom_range(0, 79) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ps  = ($urandom_range(0, 4) == 0);
      br  = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      #1;

      word  = tag(m_pc);
      br_al = {br[31:2], 2'b00};
      take  = ps && !st;

      if (rst) begin
        e_req = 0; e_fv = 0; e_instr = 32'h0; e_is = 0;
      end else if (m_holding) begin
        e_req = 0; e_fv = 1; e_instr = m_held_word; e_is = 0;
      end else if (m_redirect_waiting) begin
        e_req = 1; e_fv = 0; e_instr = 32'h0; e_is = 1;
      end else begin
        e_req = 1; e_fv = rdy; e_instr = rdy ? word : 32'h0; e_is = !rdy;
      end

      check_all(1000 + cyc, m_known, m_pc, e_req, e_fv, e_instr, e_is);

      // Advance the model across the coming clock edge.
      if (rst) begin
        m_pc = 32'h0; m_known = 1'b1;
        m_holding = 1'b0; m_held_word = 32'h0;
        m_redirect_waiting = 1'b0; m_redirect_to = 32'h0;
      end else if (m_holding) begin
        if (!st) begin
          m_pc      = ps ? br_al : m_pc + 32'd4;
          m_holding = 1'b0;
        end
      end else if (m_redirect_waiting) begin
        if (take) m_redirect_to = br_al;
        if (rdy) begin
          m_pc = m_redirect_to;
          m_redirect_waiting = 1'b0;
        end
      end else if (rdy) begin
        if (st) begin
          m_holding   = 1'b1;
          m_held_word = word;
        end else begin
          m_pc = ps ? br_al : m_pc + 32'd4;
        end
      end else if (take) begin
        m_redirect_waiting = 1'b1;
        m_redirect_to      = br_al;
      end

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
